// File: rtl/range_stream_driver.sv
`default_nettype none
// ============================================================================
// Module      : range_stream_driver
// Description : Transmit-side companion to the range finder. It accepts one
//               burst of samples over a valid/ready stream and drives the
//               finder's go/data/finish interface with correct framing. After
//               the burst it captures the finder's range and error and returns
//               them, with a saturating beat count, over a result handshake.
//
// Ports       : clock, reset         - clock, asynchronous active-high reset
//               s_data/s_valid/s_last/s_ready
//                                    - sample stream in
//               fd_data/fd_go/fd_finish
//                                    - registered drive to the finder
//               fd_range/fd_error    - finder outputs, sampled after the burst
//               res_range/res_count/res_error/res_timeout/res_valid/res_ready
//                                    - result handshake
//
// Optional    : RANGE_STREAM_DRIVER_TIMEOUT_EN - when defined, a burst that
//               stalls for STALL_LIMIT consecutive cycles mid-stream is closed
//               and reported with res_timeout=1. When undefined, STREAM waits
//               indefinitely and res_timeout is tied 0.
//
// Revision    : 1.0 - initial release
// ============================================================================
module range_stream_driver #(
  parameter int WIDTH       = 16,
  parameter int CNT_W       = 8,
  parameter int STALL_LIMIT = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  input  logic             s_last,
  output logic             s_ready,
  output logic [WIDTH-1:0] fd_data,
  output logic             fd_go,
  output logic             fd_finish,
  input  logic [WIDTH-1:0] fd_range,
  input  logic             fd_error,
  output logic [WIDTH-1:0] res_range,
  output logic [CNT_W-1:0] res_count,
  output logic             res_error,
  output logic             res_timeout,
  output logic             res_valid,
  input  logic             res_ready
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_STREAM  = 3'd1,
    ST_TAIL    = 3'd2,
    ST_FLUSH   = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_RESULT  = 3'd5
  } state_t;

  state_t           state_q,     state_d;
  logic [WIDTH-1:0] fd_data_q,   fd_data_d;
  logic             fd_go_q,     fd_go_d;
  logic             fd_finish_q, fd_finish_d;
  logic [CNT_W-1:0] count_q,     count_d;
  logic [WIDTH-1:0] res_range_q, res_range_d;
  logic [CNT_W-1:0] res_count_q, res_count_d;
  logic             res_error_q, res_error_d;
  logic             res_valid_q, res_valid_d;

  logic             beat;
  logic [CNT_W-1:0] count_inc;

`ifdef RANGE_STREAM_DRIVER_TIMEOUT_EN
  localparam int STALL_W = $clog2(STALL_LIMIT + 1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_LIMIT - 1);

  logic [STALL_W-1:0] stall_q,       stall_d;
  logic               tmo_q,         tmo_d;
  logic               res_timeout_q, res_timeout_d;

  assign res_timeout = res_timeout_q;
`else
  // STALL_LIMIT only matters when the timeout is built in.
  logic unused_stall_limit;
  assign unused_stall_limit = |STALL_LIMIT;
  assign res_timeout        = 1'b0;
`endif

  assign s_ready   = (state_q == ST_IDLE) || (state_q == ST_STREAM);
  assign beat      = s_valid && s_ready;
  assign count_inc = (count_q == {CNT_W{1'b1}}) ? count_q : count_q + CNT_W'(1);

  assign fd_data   = fd_data_q;
  assign fd_go     = fd_go_q;
  assign fd_finish = fd_finish_q;
  assign res_range = res_range_q;
  assign res_count = res_count_q;
  assign res_error = res_error_q;
  assign res_valid = res_valid_q;

  always_comb begin
    state_d     = state_q;
    fd_data_d   = fd_data_q;
    fd_go_d     = 1'b0;
    fd_finish_d = 1'b0;
    count_d     = count_q;
    res_range_d = res_range_q;
    res_count_d = res_count_q;
    res_error_d = res_error_q;
    res_valid_d = res_valid_q;
`ifdef RANGE_STREAM_DRIVER_TIMEOUT_EN
    stall_d       = stall_q;
    tmo_d         = tmo_q;
    res_timeout_d = res_timeout_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (beat) begin
          fd_go_d   = 1'b1;
          fd_data_d = s_data;
          count_d   = CNT_W'(1);
`ifdef RANGE_STREAM_DRIVER_TIMEOUT_EN
          stall_d   = '0;
          tmo_d     = 1'b0;
`endif
          // A single-beat burst detours through TAIL so go and finish land
          // in different finder cycles.
          state_d   = s_last ? ST_TAIL : ST_STREAM;
        end
      end

      ST_STREAM: begin
        if (beat) begin
          fd_data_d = s_data;
          count_d   = count_inc;
`ifdef RANGE_STREAM_DRIVER_TIMEOUT_EN
          stall_d   = '0;
`endif
          if (s_last) begin
            fd_finish_d = 1'b1;
            state_d     = ST_FLUSH;
          end
        end
`ifdef RANGE_STREAM_DRIVER_TIMEOUT_EN
        else if (stall_q == STALL_LAST) begin
          // This idle cycle is the STALL_LIMIT-th in a row: close the burst
          // on the held sample, which leaves the finder's max/min unchanged.
          fd_finish_d = 1'b1;
          tmo_d       = 1'b1;
          state_d     = ST_FLUSH;
        end else begin
          stall_d = stall_q + STALL_W'(1);
        end
`endif
      end

      ST_TAIL: begin
        fd_finish_d = 1'b1;
        state_d     = ST_FLUSH;
      end

      ST_FLUSH: begin
        state_d = ST_CAPTURE;
      end

      ST_CAPTURE: begin
        // The finder has consumed finish and now presents max-min.
        res_range_d = fd_range;
        res_error_d = fd_error;
        res_count_d = count_q;
        res_valid_d = 1'b1;
`ifdef RANGE_STREAM_DRIVER_TIMEOUT_EN
        res_timeout_d = tmo_q;
`endif
        state_d     = ST_RESULT;
      end

      ST_RESULT: begin
        if (res_valid_q && res_ready) begin
          res_valid_d = 1'b0;
`ifdef RANGE_STREAM_DRIVER_TIMEOUT_EN
          res_timeout_d = 1'b0;
`endif
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      fd_data_q   <= '0;
      fd_go_q     <= 1'b0;
      fd_finish_q <= 1'b0;
      count_q     <= '0;
      res_range_q <= '0;
      res_count_q <= '0;
      res_error_q <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fd_data_q   <= fd_data_d;
      fd_go_q     <= fd_go_d;
      fd_finish_q <= fd_finish_d;
      count_q     <= count_d;
      res_range_q <= res_range_d;
      res_count_q <= res_count_d;
      res_error_q <= res_error_d;
      res_valid_q <= res_valid_d;
    end
  end

`ifdef RANGE_STREAM_DRIVER_TIMEOUT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_q       <= '0;
      tmo_q         <= 1'b0;
      res_timeout_q <= 1'b0;
    end else begin
      stall_q       <= stall_d;
      tmo_q         <= tmo_d;
      res_timeout_q <= res_timeout_d;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_range_stream_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_range_stream_driver
// Description : Scoreboard bench for range_stream_driver with a behavioural
//               range-finder stand-in and randomized bursts.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_range_stream_driver;

  localparam int WIDTH       = 16;
  localparam int CNT_W       = 8;
  localparam int STALL_LIMIT = 16;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic             clock = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] s_data;
  logic             s_valid;
  logic             s_last;
  logic             s_ready;
  logic [WIDTH-1:0] fd_data;
  logic             fd_go;
  logic             fd_finish;
  logic [WIDTH-1:0] fd_range;
  logic             fd_error;
  logic [WIDTH-1:0] res_range;
  logic [CNT_W-1:0] res_count;
  logic             res_error;
  logic             res_timeout;
  logic             res_valid;
  logic             res_ready;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  range_stream_driver #(
    .WIDTH      (WIDTH),
    .CNT_W      (CNT_W),
    .STALL_LIMIT(STALL_LIMIT)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_last     (s_last),
    .s_ready    (s_ready),
    .fd_data    (fd_data),
    .fd_go      (fd_go),
    .fd_finish  (fd_finish),
    .fd_range   (fd_range),
    .fd_error   (fd_error),
    .res_range  (res_range),
    .res_count  (res_count),
    .res_error  (res_error),
    .res_timeout(res_timeout),
    .res_valid  (res_valid),
    .res_ready  (res_ready)
  );

  // --------------------------------------------------------------------------
  // Range finder stand-in: tracks max/min from go through finish, then shows
  // max-min. fd_error is whatever the stimulus injects for the current burst.
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] f_max, f_min, f_rng;
  logic             f_busy;
  logic             inject_err;

  function automatic logic [WIDTH-1:0] max2(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return (a > b) ? a : b;
  endfunction
  function automatic logic [WIDTH-1:0] min2(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return (a < b) ? a : b;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      f_max  <= '0;
      f_min  <= '0;
      f_rng  <= '0;
      f_busy <= 1'b0;
    end else if (fd_go) begin
      f_max  <= fd_data;
      f_min  <= fd_data;
      f_busy <= 1'b1;
    end else if (f_busy) begin
      f_max <= max2(fd_data, f_max);
      f_min <= min2(fd_data, f_min);
      if (fd_finish) begin
        f_rng  <= max2(fd_data, f_max) - min2(fd_data, f_min);
        f_busy <= 1'b0;
      end
    end
  end

  assign fd_range = f_rng;
  assign fd_error = inject_err;

  // --------------------------------------------------------------------------
  // Scoreboard
  // --------------------------------------------------------------------------
  typedef struct packed {
    logic [WIDTH-1:0] rng;
    logic [CNT_W-1:0] cnt;
    logic             err;
  } exp_t;

  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Monitor: a transaction-level view of the protocol. Beats observed at one
  // negedge are expected on fd_* at the next; a single-beat burst finishes one
  // cycle later still. s_ready is low from the last beat until the result
  // handshake completes.
  // --------------------------------------------------------------------------
  initial begin
    int               cyc;
    logic             m_in_burst, m_closed;
    logic [WIDTH-1:0] m_fd_data;
    logic             p_acc, p_first, p_last, pend_fin;
    logic             p_rv, p_hold;
    logic [WIDTH-1:0] h_rng;
    logic [CNT_W-1:0] h_cnt;
    logic             h_err, h_tmo;
    int               last_acc_cyc, exp_lat;
    logic             acc, hs, exp_go, exp_fin;
    exp_t             e;

    cyc = 0; last_acc_cyc = 0; exp_lat = 0;
    m_in_burst = 0; m_closed = 0; m_fd_data = '0;
    p_acc = 0; p_first = 0; p_last = 0; pend_fin = 0; p_rv = 0; p_hold = 0;
    h_rng = '0; h_cnt = '0; h_err = 0; h_tmo = 0;
    forever begin
      @(negedge clock);
      cyc++;
      if (reset) begin
        m_in_burst = 0; m_closed = 0; m_fd_data = '0;
        p_acc = 0; pend_fin = 0; p_rv = 0; p_hold = 0;
        continue;
      end

      exp_go  = p_acc && p_first;
      exp_fin = (p_acc && p_last && !p_first) || pend_fin;
      check("fd_go", 32'(fd_go), 32'(exp_go));
      check("fd_finish", 32'(fd_finish), 32'(exp_fin));
      check("fd_data", 32'(fd_data), 32'(m_fd_data));
      check("s_ready", 32'(s_ready), 32'(!m_closed));
      pend_fin = p_acc && p_first && p_last;

      if (res_valid && !p_rv)
        check("res_latency", 32'(cyc - last_acc_cyc), 32'(exp_lat));
      if (p_hold) begin
        check("hold_valid", 32'(res_valid), 32'd1);
        check("hold_range", 32'(res_range), 32'(h_rng));
        check("hold_count", 32'(res_count), 32'(h_cnt));
        check("hold_error", 32'(res_error), 32'(h_err));
        check("hold_timeout", 32'(res_timeout), 32'(h_tmo));
      end

      hs = res_valid && res_ready;
      if (hs) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_result: got range %0d with no expected entry", res_range);
        end else begin
          e = exp_q.pop_front();
          check("res_range", 32'(res_range), 32'(e.rng));
          check("res_count", 32'(res_count), 32'(e.cnt));
          check("res_error", 32'(res_error), 32'(e.err));
          check("res_timeout", 32'(res_timeout), 32'd0);
        end
      end

      p_hold = res_valid && !res_ready;
      h_rng = res_range; h_cnt = res_count; h_err = res_error; h_tmo = res_timeout;
      p_rv = res_valid;

      acc = s_valid && s_ready;
      if (acc) begin
        p_first    = !m_in_burst;
        p_last     = s_last;
        m_fd_data  = s_data;
        m_in_burst = !s_last;
        if (s_last) begin
          m_closed     = 1;
          last_acc_cyc = cyc;
          exp_lat      = p_first ? 4 : 3;
        end
      end
      p_acc = acc;
      if (hs) m_closed = 0;
    end
  end

  // --------------------------------------------------------------------------
  // Result-consumer driver: 0 = always ready, 1 = random, 2 = never ready
  // --------------------------------------------------------------------------
  int rr_mode = 0;
  initial begin
    res_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      res_ready = (rr_mode == 0) ? 1'b1 : (rr_mode == 1) ? 1'($urandom % 2) : 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] burst[$];

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic drive_beat(input logic [WIDTH-1:0] d, input logic last, output logic ok);
    int n;
    n  = 0;
    ok = 1'b0;
    s_valid = 1'b1; s_data = d; s_last = last;
    while (!ok && n < 200) begin
      @(negedge clock);
      ok = s_ready;
      n++;
      @(posedge clock);
      #1;
    end
    s_valid = 1'b0; s_last = 1'b0;
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL beat_wait: s_ready stayed 0 for %0d cycles, required 1", n);
    end
  endtask

  task automatic send_burst(input int gap_fixed, input int gap_rand, input logic err);
    logic             ok;
    logic [WIDTH-1:0] mx, mn;
    int               n;
    exp_t             e;
    n  = burst.size();
    mx = burst[0];
    mn = burst[0];
    for (int i = 0; i < n; i++) begin
      if (i > 0) idle(gap_fixed + ((gap_rand > 0) ? int'($urandom_range(gap_rand, 0)) : 0));
      drive_beat(burst[i], (i == n - 1), ok);
      if (!ok) return;
      if (i == 0) inject_err = err;
      mx = max2(mx, burst[i]);
      mn = min2(mn, burst[i]);
    end
    e.rng = mx - mn;
    e.cnt = (n > CNT_MAX) ? CNT_W'(CNT_MAX) : CNT_W'(n);
    e.err = err;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clock);
      n++;
    end
    #1;
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_fd_data"}, 32'(fd_data), 32'd0);
    check({tag, "_fd_go"}, 32'(fd_go), 32'd0);
    check({tag, "_fd_finish"}, 32'(fd_finish), 32'd0);
    check({tag, "_res_range"}, 32'(res_range), 32'd0);
    check({tag, "_res_count"}, 32'(res_count), 32'd0);
    check({tag, "_res_error"}, 32'(res_error), 32'd0);
    check({tag, "_res_timeout"}, 32'(res_timeout), 32'd0);
    check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
  endtask

  initial begin
    logic ok;
    int   len;
    reset = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0; inject_err = 1'b0;
    #2;
    check_zero("reset");
    idle(3);
    @(posedge clock);
    #1;
    reset = 1'b0;
    idle(1);

    // Back-to-back burst, consumer always ready.
    rr_mode = 0;
    burst = '{16'd5, 16'd9, 16'd2};
    send_burst(0, 0, 1'b0);
    wait_drain();

    // Single-beat burst.
    burst = '{16'd42};
    send_burst(0, 0, 1'b0);
    wait_drain();

    // Source stall mid-burst: fd_data must hold 5.
    burst = '{16'd5, 16'd9};
    send_burst(2, 0, 1'b0);
    wait_drain();

    // Consumer stalls; the next burst is already offered while blocked.
    rr_mode = 2;
    burst = '{16'd7, 16'd3, 16'd11};
    send_burst(0, 0, 1'b1);
    fork
      begin
        idle(8);
        rr_mode = 0;
      end
      begin
        burst = '{16'd100, 16'd60};
        send_burst(0, 0, 1'b0);
      end
    join
    wait_drain();

    // Reset in the middle of burst 3,8; the partial burst is dropped.
    drive_beat(16'd3, 1'b0, ok);
    drive_beat(16'd8, 1'b0, ok);
    @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    check_zero("midreset");
    @(posedge clock);
    #1;
    reset = 1'b0;
    inject_err = 1'b0;
    idle(1);
    burst = '{16'd1, 16'd4};
    send_burst(0, 0, 1'b0);
    wait_drain();

    // Long burst: beat count saturates.
    burst.delete();
    for (int i = 0; i < 300; i++) burst.push_back(WIDTH'($urandom));
    send_burst(0, 0, 1'b0);
    wait_drain();

    // Randomized bursts with random stalls and random consumer readiness.
    rr_mode = 1;
    for (int b = 0; b < 25; b++) begin
      burst.delete();
      len = int'($urandom_range(6, 1));
      for (int i = 0; i < len; i++) burst.push_back(WIDTH'($urandom));
      idle(int'($urandom_range(2, 0)));
      send_burst(0, 3, 1'($urandom % 2));
    end
    rr_mode = 0;
    wait_drain();

    idle(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/range_stream_driver.md
Name: range_stream_driver

Overview:
- Transmit-side companion to the range-finder datapath. It accepts a burst of samples over a valid/ready stream and drives the finder's go/data/finish interface with correct framing.
- After the burst it captures the finder's range and error outputs and returns them, with a beat count, over a result handshake.
- Sits between a sample source (test harness or upstream logic) and the range finder; one burst is in flight at a time.

Parameters:
WIDTH, 16, sample and range width
CNT_W, 8, width of beat counter (saturating)
STALL_LIMIT, 16, consecutive idle cycles mid-burst before timeout abort (used only with the optional feature)

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high reset
s_data  input  WIDTH  sample in
s_valid  input  1  sample valid
s_last  input  1  final sample of burst, qualified by s_valid
s_ready  output  1  driver accepts sample this cycle
fd_data  output  WIDTH  data to finder (registered)
fd_go  output  1  burst start pulse to finder (registered)
fd_finish  output  1  burst end pulse to finder (registered)
fd_range  input  WIDTH  range from finder
fd_error  input  1  debug_error from finder
res_range  output  WIDTH  captured range
res_count  output  CNT_W  beats accepted in burst, saturating at 2^CNT_W-1
res_error  output  1  captured finder error
res_timeout  output  1  burst was closed by stall timeout
res_valid  output  1  result available; held until res_ready
res_ready  input  1  result consumer ready

Behaviour:
- Reset is asynchronous and active-high. On reset: state IDLE; fd_data, fd_go, fd_finish, res_range, res_count, res_error, res_timeout and res_valid all 0; counters 0.
- Transfer rule: a beat transfers when s_valid && s_ready. res transfers when res_valid && res_ready.
- s_ready = 1 only in IDLE and STREAM.
- fd_go and fd_finish are single-cycle pulses, 0 by default. They are never high in the same cycle.
- fd_data holds its last value unless a new beat is accepted.
- Holding data is idempotent for the finder (max/min unchanged), so mid-burst source stalls are absorbed by repeating the held sample.
- States: IDLE, STREAM, TAIL, FLUSH, CAPTURE, RESULT.
- IDLE, beat accepted:
  - fd_go<=1, fd_data<=s_data, count<=1.
  - Next state is TAIL if s_last, else STREAM.
- STREAM, beat accepted:
  - fd_data<=s_data, count++ (saturating), stall counter cleared.
  - If s_last: fd_finish<=1, next state FLUSH.
- STREAM, no beat: fd_data held; stall counter increments.
- TAIL (single-beat burst): s_ready=0; fd_finish<=1 with fd_data held; next state FLUSH. A 1-beat burst therefore occupies 2 finder cycles (go, then finish), so go and finish never coincide.
- FLUSH: the fd_finish pulse is visible this cycle; next state CAPTURE.
- CAPTURE:
  - The finder is now IDLE, so fd_range = max-min.
  - res_range<=fd_range, res_error<=fd_error, res_count<=count, res_valid<=1; next state RESULT.
- RESULT: res_* held stable. On res_valid && res_ready: res_valid<=0, res_timeout<=0, next state IDLE. New beats are accepted from the following cycle.
- Latency, no stalls: last beat accepted at cycle N gives fd_finish at N+1, capture at N+2, res_valid at N+3. Single beat accepted at N gives fd_go at N+1, fd_finish at N+2, res_valid at N+4.
- Reset mid-operation: the driver returns to IDLE immediately and any partial burst is dropped. The finder shares reset.
- res_range is passed through unchecked. A finder error (e.g. spurious go from elsewhere) is reported via res_error only.

Optional Feature:
- Macro: RANGE_STREAM_DRIVER_TIMEOUT_EN.
- Defined: in STREAM, when the stall counter reaches STALL_LIMIT consecutive cycles without a beat:
  - fd_finish<=1 with fd_data held, next state FLUSH.
  - res_timeout is set and reported with the result.
- Not defined: STREAM waits indefinitely, the stall counter is not instantiated, and res_timeout is tied 0.

Test Plan:
- Burst 5,9,2 back-to-back, res_ready=1: fd_go with data 5 at cycle 1, fd_finish with data 2 at cycle 3; res_valid at cycle 5 with range=7, count=3, error=0.
- Single beat 42 with s_last: fd_go at cycle 1, fd_finish at cycle 2 with data 42; s_ready=0 in TAIL; result range=0, count=1; go and finish never coincide.
- Burst 5, two idle cycles, then 9 with s_last: fd_data stays 5 during the stall; result range=4, count=2.
- res_ready held 0 for 5 cycles with s_valid=1: res_* stable, s_ready=0 throughout; resumes in IDLE one cycle after the handshake.
- Assert reset during STREAM of burst 3,8: all outputs return to 0 asynchronously; next burst 1,4 gives range=3, count=2.
- With RANGE_STREAM_DRIVER_TIMEOUT_EN, STALL_LIMIT=4: beat 10, then s_valid=0 → fd_finish after 4 idle cycles; result range=0, count=1, timeout=1.
